// File: rtl/des_decrypt_core.sv
// Iterative DES block engine: one Feistel round per clock, valid/ready in and out.
// Default build decrypts only (subkeys K16..K1).
// Define DES_CORE_ENCRYPT_EN to add an `encrypt` input that selects K1..K16.

// DES S-boxes: 6-bit in, 4-bit out. Row = {x5,x0}, column = x4..x1.
// Each 256-bit table holds 64 nibbles, with entry 0 in the top nibble.
module s1 (input logic [5:0] i_x, output logic [3:0] o_y);
  localparam logic [255:0] T = 256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D;
  logic [5:0] w_idx;
  assign w_idx = {i_x[5], i_x[0], i_x[4:1]};
  assign o_y = T[(8'd252 - {w_idx, 2'b00}) +: 4];
endmodule

module s2 (input logic [5:0] i_x, output logic [3:0] o_y);
  localparam logic [255:0] T = 256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9;
  logic [5:0] w_idx;
  assign w_idx = {i_x[5], i_x[0], i_x[4:1]};
  assign o_y = T[(8'd252 - {w_idx, 2'b00}) +: 4];
endmodule

module s3 (input logic [5:0] i_x, output logic [3:0] o_y);
  localparam logic [255:0] T = 256'hA09E63F51DC7B428_D709346A285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C;
  logic [5:0] w_idx;
  assign w_idx = {i_x[5], i_x[0], i_x[4:1]};
  assign o_y = T[(8'd252 - {w_idx, 2'b00}) +: 4];
endmodule

module s4 (input logic [5:0] i_x, output logic [3:0] o_y);
  localparam logic [255:0] T = 256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E;
  logic [5:0] w_idx;
  assign w_idx = {i_x[5], i_x[0], i_x[4:1]};
  assign o_y = T[(8'd252 - {w_idx, 2'b00}) +: 4];
endmodule

module s5 (input logic [5:0] i_x, output logic [3:0] o_y);
  localparam logic [255:0] T = 256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453;
  logic [5:0] w_idx;
  assign w_idx = {i_x[5], i_x[0], i_x[4:1]};
  assign o_y = T[(8'd252 - {w_idx, 2'b00}) +: 4];
endmodule

module s6 (input logic [5:0] i_x, output logic [3:0] o_y);
  localparam logic [255:0] T = 256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D;
  logic [5:0] w_idx;
  assign w_idx = {i_x[5], i_x[0], i_x[4:1]};
  assign o_y = T[(8'd252 - {w_idx, 2'b00}) +: 4];
endmodule

module s7 (input logic [5:0] i_x, output logic [3:0] o_y);
  localparam logic [255:0] T = 256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C;
  logic [5:0] w_idx;
  assign w_idx = {i_x[5], i_x[0], i_x[4:1]};
  assign o_y = T[(8'd252 - {w_idx, 2'b00}) +: 4];
endmodule

module s8 (input logic [5:0] i_x, output logic [3:0] o_y);
  localparam logic [255:0] T = 256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B;
  logic [5:0] w_idx;
  assign w_idx = {i_x[5], i_x[0], i_x[4:1]};
  assign o_y = T[(8'd252 - {w_idx, 2'b00}) +: 4];
endmodule

module des_decrypt_core (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] cipher_in,
  input  logic [63:0] key_in,
`ifdef DES_CORE_ENCRYPT_EN
  input  logic        encrypt,
`endif
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] plain_out,
  output logic        busy
);
  // Permutation tables hold 1-based DES bit numbers (DES bit 1 = MSB).
  localparam logic [0:63][6:0] IP_T = '{58,50,42,34,26,18,10,2, 60,52,44,36,28,20,12,4,
    62,54,46,38,30,22,14,6, 64,56,48,40,32,24,16,8, 57,49,41,33,25,17,9,1,
    59,51,43,35,27,19,11,3, 61,53,45,37,29,21,13,5, 63,55,47,39,31,23,15,7};
  localparam logic [0:63][6:0] FP_T = '{40,8,48,16,56,24,64,32, 39,7,47,15,55,23,63,31,
    38,6,46,14,54,22,62,30, 37,5,45,13,53,21,61,29, 36,4,44,12,52,20,60,28,
    35,3,43,11,51,19,59,27, 34,2,42,10,50,18,58,26, 33,1,41,9,49,17,57,25};
  localparam logic [0:55][6:0] PC1_T = '{57,49,41,33,25,17,9, 1,58,50,42,34,26,18,
    10,2,59,51,43,35,27, 19,11,3,60,52,44,36, 63,55,47,39,31,23,15,
    7,62,54,46,38,30,22, 14,6,61,53,45,37,29, 21,13,5,28,20,12,4};
  localparam logic [0:47][6:0] PC2_T = '{14,17,11,24,1,5, 3,28,15,6,21,10,
    23,19,12,4,26,8, 16,7,27,20,13,2, 41,52,31,37,47,55, 30,40,51,45,33,48,
    44,49,39,56,34,53, 46,42,50,36,29,32};
  localparam logic [0:47][6:0] E_T = '{32,1,2,3,4,5, 4,5,6,7,8,9, 8,9,10,11,12,13,
    12,13,14,15,16,17, 16,17,18,19,20,21, 20,21,22,23,24,25, 24,25,26,27,28,29, 28,29,30,31,32,1};
  localparam logic [0:31][6:0] P_T = '{16,7,20,21,29,12,28,17, 1,15,23,26,5,18,31,10,
    2,8,24,14,32,27,3,9, 19,13,30,6,22,11,4,25};

  function automatic logic [63:0] f_ip(input logic [63:0] d);
    for (int i = 0; i < 64; i++) f_ip[63-i] = d[64-int'(IP_T[i])];
  endfunction
  function automatic logic [63:0] f_fp(input logic [63:0] d);
    for (int i = 0; i < 64; i++) f_fp[63-i] = d[64-int'(FP_T[i])];
  endfunction
  function automatic logic [55:0] f_pc1(input logic [63:0] d);
    for (int i = 0; i < 56; i++) f_pc1[55-i] = d[64-int'(PC1_T[i])];
  endfunction
  function automatic logic [47:0] f_pc2(input logic [55:0] d);
    for (int i = 0; i < 48; i++) f_pc2[47-i] = d[56-int'(PC2_T[i])];
  endfunction
  function automatic logic [47:0] f_e(input logic [31:0] d);
    for (int i = 0; i < 48; i++) f_e[47-i] = d[32-int'(E_T[i])];
  endfunction
  function automatic logic [31:0] f_p(input logic [31:0] d);
    for (int i = 0; i < 32; i++) f_p[31-i] = d[32-int'(P_T[i])];
  endfunction

  typedef enum logic [1:0] {S_IDLE, S_ROUND, S_DONE} state_t;

  state_t      r_state;
  logic [3:0]  r_rnd;
  logic [31:0] r_l, r_r;
  logic [27:0] r_c, r_d;
  logic        w_enc;
  logic [27:0] w_c_rot, w_d_rot;
  logic [47:0] w_key, w_sx;
  logic [31:0] w_sy, w_r_new;

`ifdef DES_CORE_ENCRYPT_EN
  logic r_enc;
  assign w_enc = r_enc;
`else
  assign w_enc = 1'b0;
`endif

  assign in_ready = (r_state == S_IDLE);
  assign busy     = (r_state == S_ROUND) || (r_state == S_DONE);

  // Per-round key schedule: rotate C/D (right for decrypt, left for encrypt) by the table amount.
  // The two tables differ only at round 0: decrypt starts from C0/D0 = C16/D16 unshifted.
  always_comb begin
    w_c_rot = r_c;
    w_d_rot = r_d;
    if (r_rnd == 4'd0 && !w_enc) begin
      w_c_rot = r_c;
      w_d_rot = r_d;
    end else if (r_rnd == 4'd0 || r_rnd == 4'd1 || r_rnd == 4'd8 || r_rnd == 4'd15) begin
      w_c_rot = w_enc ? {r_c[26:0], r_c[27]} : {r_c[0], r_c[27:1]};
      w_d_rot = w_enc ? {r_d[26:0], r_d[27]} : {r_d[0], r_d[27:1]};
    end else begin
      w_c_rot = w_enc ? {r_c[25:0], r_c[27:26]} : {r_c[1:0], r_c[27:2]};
      w_d_rot = w_enc ? {r_d[25:0], r_d[27:26]} : {r_d[1:0], r_d[27:2]};
    end
  end

  assign w_key = f_pc2({w_c_rot, w_d_rot});
  assign w_sx  = f_e(r_r) ^ w_key;

  s1 u_s1 (.i_x(w_sx[47:42]), .o_y(w_sy[31:28]));
  s2 u_s2 (.i_x(w_sx[41:36]), .o_y(w_sy[27:24]));
  s3 u_s3 (.i_x(w_sx[35:30]), .o_y(w_sy[23:20]));
  s4 u_s4 (.i_x(w_sx[29:24]), .o_y(w_sy[19:16]));
  s5 u_s5 (.i_x(w_sx[23:18]), .o_y(w_sy[15:12]));
  s6 u_s6 (.i_x(w_sx[17:12]), .o_y(w_sy[11:8]));
  s7 u_s7 (.i_x(w_sx[11:6]),  .o_y(w_sy[7:4]));
  s8 u_s8 (.i_x(w_sx[5:0]),   .o_y(w_sy[3:0]));

  assign w_r_new = r_l ^ f_p(w_sy);

  // Control FSM and datapath registers: accept, iterate 16 rounds, hold result until taken.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_rnd     <= 4'd0;
      r_l       <= 32'd0;
      r_r       <= 32'd0;
      r_c       <= 28'd0;
      r_d       <= 28'd0;
      out_valid <= 1'b0;
      plain_out <= 64'd0;
`ifdef DES_CORE_ENCRYPT_EN
      r_enc     <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: if (in_valid) begin
          {r_l, r_r} <= f_ip(cipher_in);
          {r_c, r_d} <= f_pc1(key_in);
          r_rnd      <= 4'd0;
`ifdef DES_CORE_ENCRYPT_EN
          r_enc      <= encrypt;
`endif
          r_state    <= S_ROUND;
        end
        S_ROUND: begin
          r_l   <= r_r;
          r_r   <= w_r_new;
          r_c   <= w_c_rot;
          r_d   <= w_d_rot;
          r_rnd <= r_rnd + 4'd1;
          if (r_rnd == 4'd15) begin
            // Last round: undo the final swap, so the halves go out as {R16, L16}.
            plain_out <= f_fp({w_r_new, r_r});
            out_valid <= 1'b1;
            r_state   <= S_DONE;
          end
        end
        S_DONE: if (out_ready) begin
          out_valid <= 1'b0;
          r_state   <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: doc/des_decrypt_core.md
# des_decrypt_core

Iterative single-block DES decryption engine: accepts a 64-bit ciphertext block and 64-bit key through a valid/ready handshake. It runs the 16 Feistel rounds with the reversed subkey order, one round per clock, and presents the 64-bit plaintext through a valid/ready output handshake. It sits on the decrypt side of the crypto datapath, paired with the existing encrypt path. It reuses the team's eight 6-to-4 S-box blocks (s1..s8) unchanged, as combinational instances inside the round function.

## Interface
- No parameters.
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  ciphertext/key present.
- in_ready  output  1  core can accept; high only in IDLE.
- cipher_in  input  64  ciphertext block, bit 63 = DES bit 1.
- key_in  input  64  DES key incl. parity bits (parity ignored), bit 63 = DES bit 1.
- out_valid  output  1  plaintext valid.
- out_ready  input  1  downstream accepts plaintext.
- plain_out  output  64  plaintext block, registered.
- busy  output  1  high in ROUND and DONE.

## Operation
- States: IDLE, ROUND, DONE.
- IDLE: in_ready=1. On in_valid && in_ready:
  - register L,R = IP(cipher_in).
  - register C,D = PC-1(key_in).
  - round counter rnd=0; go to ROUND.
- Subkey for round rnd = PC-2(C',D'), where C',D' = C,D rotated right by the decrypt shift amount for rnd.
  - Shift table for rnd 0..15: 0,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1.
  - The rotated C',D' are written back to C,D.
  - Round 0 therefore uses K16 and round 15 uses K1.
- ROUND: each edge updates L<=R and R<=L ^ f(R, subkey).
  - f = E-expansion, XOR with subkey, s1..s8 on 6-bit slices (slice 0 = bits 47:42 to s1), then P permutation.
  - rnd increments by 1 each edge.
- On the edge where rnd==15:
  - plain_out <= FP({R_new, L_new}) (final swap undone).
  - out_valid <= 1; state goes to DONE.
- DONE: plain_out and out_valid are held stable until out_valid && out_ready. On that edge out_valid <= 0 and state goes to IDLE.
- in_valid outside IDLE is ignored; cipher_in and key_in are sampled only on the acceptance edge.
- rst at any time, including mid-ROUND or in DONE, aborts the block in progress with no partial output.
- Reset values: state=IDLE, out_valid=0, plain_out=0, busy=0, in_ready=1 (the cycle after rst deasserts), rnd=0, L/R/C/D=0.

## Timing
- Acceptance edge E0. Rounds are applied on edges E1..E16. out_valid is visible immediately after E16.
  - Latency is 16 clocks from acceptance to out_valid.
- With out_ready held high, out_valid is high for exactly one cycle. The core returns to IDLE on E17 and can accept again on E18.
  - Minimum initiation interval: 18 cycles.
- out_ready low in DONE stalls indefinitely; plain_out must not change while stalled.
- Simultaneous rst and a handshake on the same edge: rst wins.
- in_ready and busy are decoded combinationally from the state register.

## Configuration
- Macro: DES_CORE_ENCRYPT_EN.
- Defined:
  - Adds input port `encrypt` (1 bit), sampled on the acceptance edge and held internally for the block.
  - When encrypt=1: each round rotates C,D left before PC-2, with shift table 1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1, so rounds use K1..K16. The output is ciphertext.
  - When encrypt=0: behaviour is as described above.
  - Latency and handshake are identical in both modes.
- Undefined: no `encrypt` port; decrypt only.

## Test plan
- Reset, then cipher_in=85E813540F0AB405, key_in=133457799BBCDFF1 -> out_valid 16 cycles after acceptance, plain_out=0123456789ABCDEF.
- key_in=0000000000000000, cipher_in=8CA64DE9C1B123A7 -> plain_out=0000000000000000.
- Backpressure: key_in=FFFFFFFFFFFFFFFF, cipher_in=7359B2163E4EDC58, out_ready low for 10 cycles -> plain_out=FFFFFFFFFFFFFFFF held stable, in_ready=0 and busy=1 throughout. The next block is accepted 2 cycles after out_ready rises.
- Assert rst at round 8 with in_valid held high -> no out_valid; outputs return to reset values. A fresh 85E8.../1334... block afterwards yields 0123456789ABCDEF.
- in_valid pulsed with garbage data during ROUND -> ignored; the result equals that of the originally accepted block.
- With DES_CORE_ENCRYPT_EN: encrypt=1, plain 0123456789ABCDEF, key 133457799BBCDFF1 -> 85E813540F0AB405. Feeding that result back with encrypt=0 returns 0123456789ABCDEF.
